// File: rtl/cpu_types_pkg.sv
// Shared CPU types: register index and hazard controller state encoding.
package cpu_types_pkg;

  localparam int unsigned REG_W = 5;

  typedef logic [REG_W-1:0] regbits_t;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } hazard_state_t;

endpackage

// File: rtl/hazard_if.sv
// Bundle of hazard-controller signals with per-stage forwarding arrays.
interface hazard_if
  import cpu_types_pkg::*;
#(
  parameter int unsigned FWD_STAGES = 2,
  parameter int unsigned CNT_W      = 32,
  localparam int unsigned FSEL_W    = $clog2(FWD_STAGES + 1)
);
  regbits_t                rs_id, rt_id, rs_ex, rt_ex, wsel_ex;
  logic                    RegWrite_ex, MemRead_ex;
  regbits_t                wsel_fwd [FWD_STAGES];
  logic [FWD_STAGES-1:0]   RegWrite_fwd;
  logic                    branch_taken, dmem_req, ihit, dhit, halt_wb, flush_done;
  logic [FSEL_W-1:0]       forwardA, forwardB;
  logic                    pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic                    ifid_flush, idex_flush, exmem_flush;
  logic                    flush_req, halt;
  logic [CNT_W-1:0]        stall_cnt, flush_cnt;

  modport hi (
    input  rs_id, rt_id, rs_ex, rt_ex, wsel_ex, RegWrite_ex, MemRead_ex,
           wsel_fwd, RegWrite_fwd, branch_taken, dmem_req, ihit, dhit,
           halt_wb, flush_done,
    output forwardA, forwardB, pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, exmem_flush, flush_req, halt,
           stall_cnt, flush_cnt
  );

  modport tb (
    output rs_id, rt_id, rs_ex, rt_ex, wsel_ex, RegWrite_ex, MemRead_ex,
           wsel_fwd, RegWrite_fwd, branch_taken, dmem_req, ihit, dhit,
           halt_wb, flush_done,
    input  forwardA, forwardB, pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, exmem_flush, flush_req, halt,
           stall_cnt, flush_cnt
  );
endinterface

// File: rtl/fwd_select.sv
// Priority search over forwarding stages; the stage nearest EX wins, $0 never forwards.
module fwd_select
  import cpu_types_pkg::*;
#(
  parameter int unsigned FWD_STAGES = 2,
  localparam int unsigned FSEL_W    = $clog2(FWD_STAGES + 1)
) (
  input  regbits_t              i_src,
  input  regbits_t              i_wsel [FWD_STAGES],
  input  logic [FWD_STAGES-1:0] i_wen,
  output logic [FSEL_W-1:0]     o_sel
);

  // Scan far-to-near so the lowest matching index is the one left standing.
  always_comb begin
    o_sel = '0;
    for (int k = int'(FWD_STAGES) - 1; k >= 0; k--) begin
      if (i_wen[k] && (i_wsel[k] != '0) && (i_wsel[k] == i_src)) begin
        o_sel = FSEL_W'(k + 1);
      end
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard controller: forwarding selects, load-use stall, branch flush,
// halt/dcache-flush sequencing and saturating stall/flush counters.
module hazard_unit
  import cpu_types_pkg::*;
#(
  parameter int unsigned CPUS       = 1,
  parameter int unsigned CPUID      = 0,
  parameter int unsigned FWD_STAGES = 2,
  parameter int unsigned CNT_W      = 32,
  localparam int unsigned FSEL_W    = $clog2(FWD_STAGES + 1)
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  regbits_t              rs_id,
  input  regbits_t              rt_id,
  input  regbits_t              rs_ex,
  input  regbits_t              rt_ex,
  input  regbits_t              wsel_ex,
  input  logic                  RegWrite_ex,
  input  logic                  MemRead_ex,
  input  regbits_t              wsel_fwd [FWD_STAGES],
  input  logic [FWD_STAGES-1:0] RegWrite_fwd,
  input  logic                  branch_taken,
  input  logic                  dmem_req,
  input  logic                  ihit,
  input  logic                  dhit,
  input  logic                  halt_wb,
  input  logic                  flush_done,
  output logic [FSEL_W-1:0]     forwardA,
  output logic [FSEL_W-1:0]     forwardB,
  output logic                  pc_en,
  output logic                  ifid_en,
  output logic                  idex_en,
  output logic                  exmem_en,
  output logic                  memwb_en,
  output logic                  ifid_flush,
  output logic                  idex_flush,
  output logic                  exmem_flush,
  output logic                  flush_req,
  output logic                  halt,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  if (CPUID >= CPUS) begin : g_bad_cpuid
    $error("hazard_unit: CPUID must be below CPUS");
  end

  hazard_state_t    r_state, w_next;
  logic             r_halt, r_flush_req;
  logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;
  logic             w_adv, w_lu, w_stall_inc, w_flush_inc;

  fwd_select #(.FWD_STAGES(FWD_STAGES)) u_fwd_a (
    .i_src(rs_ex), .i_wsel(wsel_fwd), .i_wen(RegWrite_fwd), .o_sel(forwardA)
  );

  fwd_select #(.FWD_STAGES(FWD_STAGES)) u_fwd_b (
    .i_src(rt_ex), .i_wsel(wsel_fwd), .i_wen(RegWrite_fwd), .o_sel(forwardB)
  );

  assign w_adv = dmem_req ? dhit : ihit;
  assign w_lu  = RegWrite_ex && MemRead_ex && (wsel_ex != '0) &&
                 ((wsel_ex == rs_id) || (wsel_ex == rt_id));

  assign w_stall_inc = (r_state == RUN) && (!w_adv || w_lu);
  assign w_flush_inc = (r_state == RUN) && branch_taken && w_adv;

  // Next state and latch controls; branch redirect overrides a load-use stall.
  always_comb begin
    w_next      = r_state;
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    idex_en     = 1'b0;
    exmem_en    = 1'b0;
    memwb_en    = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    case (r_state)
      RUN: begin
        pc_en    = w_adv;
        ifid_en  = w_adv;
        idex_en  = w_adv;
        exmem_en = w_adv;
        memwb_en = w_adv;
        if (branch_taken && w_adv) begin
          ifid_flush  = 1'b1;
          idex_flush  = 1'b1;
          exmem_flush = 1'b1;
          pc_en       = 1'b1;
        end else if (w_lu && w_adv) begin
          pc_en      = 1'b0;
          ifid_en    = 1'b0;
          idex_flush = 1'b1;
        end
        if (halt_wb && w_adv) begin
          w_next   = DRAIN;
          pc_en    = 1'b0;
          ifid_en  = 1'b0;
          idex_en  = 1'b0;
          exmem_en = 1'b0;
          memwb_en = 1'b0;
        end
      end
      DRAIN: begin
        if (flush_done) w_next = HALTED;
      end
      HALTED: w_next = HALTED;
      default: w_next = RUN;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state     <= RUN;
      r_halt      <= 1'b0;
      r_flush_req <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_halt      <= (w_next == HALTED);
      r_flush_req <= (w_next == DRAIN);
    end
  end

  // Saturating performance counters, frozen outside RUN.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall_inc && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (w_flush_inc && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

  assign halt      = r_halt;
  assign flush_req = r_flush_req;
  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed checks for hazard_unit: vector table for the combinational paths,
// hand-written sequences for counters and the halt handshake.
module tb_hazard_unit;
  import cpu_types_pkg::*;

  localparam int unsigned FWD_STAGES = 2;
  localparam int unsigned CNT_W      = 4;
  localparam int unsigned NVEC       = 14;

  logic       CLK, nRST;
  regbits_t   rs_id, rt_id, rs_ex, rt_ex, wsel_ex;
  logic       RegWrite_ex, MemRead_ex;
  regbits_t   wsel_fwd [FWD_STAGES];
  logic [1:0] RegWrite_fwd;
  logic       branch_taken, dmem_req, ihit, dhit, halt_wb, flush_done;
  logic [1:0] forwardA, forwardB;
  logic       pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic       ifid_flush, idex_flush, exmem_flush, flush_req, halt;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int n_checks = 0;
  int n_errors = 0;

  hazard_unit #(.CPUS(1), .CPUID(0), .FWD_STAGES(FWD_STAGES), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .nRST(nRST),
    .rs_id(rs_id), .rt_id(rt_id), .rs_ex(rs_ex), .rt_ex(rt_ex),
    .wsel_ex(wsel_ex), .RegWrite_ex(RegWrite_ex), .MemRead_ex(MemRead_ex),
    .wsel_fwd(wsel_fwd), .RegWrite_fwd(RegWrite_fwd),
    .branch_taken(branch_taken), .dmem_req(dmem_req), .ihit(ihit), .dhit(dhit),
    .halt_wb(halt_wb), .flush_done(flush_done),
    .forwardA(forwardA), .forwardB(forwardB),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
    .memwb_en(memwb_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .exmem_flush(exmem_flush), .flush_req(flush_req), .halt(halt),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  typedef struct {
    logic [4:0] rs_id, rt_id, rs_ex, rt_ex, wsel_ex;
    logic       rw_ex, mr_ex;
    logic [4:0] w0, w1;
    logic [1:0] rwf;
    logic       br, dreq, ih, dh;
    logic [1:0] fa, fb;
    logic [4:0] en;   // {pc, ifid, idex, exmem, memwb}
    logic [2:0] fl;   // {ifid, idex, exmem}
  } vec_t;

  vec_t vecs [NVEC];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    rs_id = 5'd0; rt_id = 5'd0; rs_ex = 5'd0; rt_ex = 5'd0; wsel_ex = 5'd0;
    RegWrite_ex = 1'b0; MemRead_ex = 1'b0;
    wsel_fwd[0] = 5'd0; wsel_fwd[1] = 5'd0; RegWrite_fwd = 2'b00;
    branch_taken = 1'b0; dmem_req = 1'b0; ihit = 1'b1; dhit = 1'b0;
    halt_wb = 1'b0; flush_done = 1'b0;
  endtask

  task automatic set_lu();
    wsel_ex = 5'd8; RegWrite_ex = 1'b1; MemRead_ex = 1'b1; rs_id = 5'd8;
  endtask

  task automatic do_reset();
    #2 nRST = 1'b0;
    #2 nRST = 1'b1;
    #1;
  endtask

  function automatic logic [4:0] ens();
    return {pc_en, ifid_en, idex_en, exmem_en, memwb_en};
  endfunction

  function automatic logic [2:0] fls();
    return {ifid_flush, idex_flush, exmem_flush};
  endfunction

  initial begin
    //            rs_id rt_id rs_ex rt_ex wsel  rw mr  w0  w1  rwf   br dq ih dh  fa fb  en        fl
    vecs[0]  = '{5'd0, 5'd0, 5'd5, 5'd7, 5'd0, 0, 0, 5'd5, 5'd5, 2'b11, 0, 0, 1, 0, 2'd1, 2'd0, 5'b11111, 3'b000};
    vecs[1]  = '{5'd0, 5'd0, 5'd5, 5'd3, 5'd0, 0, 0, 5'd3, 5'd5, 2'b11, 0, 0, 1, 0, 2'd2, 2'd1, 5'b11111, 3'b000};
    vecs[2]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 0, 0, 5'd0, 5'd0, 2'b11, 0, 0, 1, 0, 2'd0, 2'd0, 5'b11111, 3'b000};
    vecs[3]  = '{5'd0, 5'd0, 5'd5, 5'd5, 5'd0, 0, 0, 5'd5, 5'd5, 2'b10, 0, 0, 1, 0, 2'd2, 2'd2, 5'b11111, 3'b000};
    vecs[4]  = '{5'd0, 5'd0, 5'd5, 5'd5, 5'd0, 0, 0, 5'd5, 5'd5, 2'b00, 0, 0, 1, 0, 2'd0, 2'd0, 5'b11111, 3'b000};
    vecs[5]  = '{5'd8, 5'd0, 5'd0, 5'd0, 5'd8, 1, 1, 5'd0, 5'd0, 2'b00, 0, 0, 1, 0, 2'd0, 2'd0, 5'b00111, 3'b010};
    vecs[6]  = '{5'd1, 5'd8, 5'd0, 5'd0, 5'd8, 1, 1, 5'd0, 5'd0, 2'b00, 0, 0, 1, 0, 2'd0, 2'd0, 5'b00111, 3'b010};
    vecs[7]  = '{5'd8, 5'd0, 5'd0, 5'd0, 5'd8, 1, 0, 5'd0, 5'd0, 2'b00, 0, 0, 1, 0, 2'd0, 2'd0, 5'b11111, 3'b000};
    vecs[8]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1, 1, 5'd0, 5'd0, 2'b00, 0, 0, 1, 0, 2'd0, 2'd0, 5'b11111, 3'b000};
    vecs[9]  = '{5'd8, 5'd0, 5'd0, 5'd0, 5'd8, 1, 1, 5'd0, 5'd0, 2'b00, 0, 0, 0, 0, 2'd0, 2'd0, 5'b00000, 3'b000};
    vecs[10] = '{5'd8, 5'd0, 5'd0, 5'd0, 5'd8, 1, 1, 5'd0, 5'd0, 2'b00, 1, 0, 1, 0, 2'd0, 2'd0, 5'b11111, 3'b111};
    vecs[11] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 0, 0, 5'd0, 5'd0, 2'b00, 1, 0, 0, 0, 2'd0, 2'd0, 5'b00000, 3'b000};
    vecs[12] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 0, 0, 5'd0, 5'd0, 2'b00, 0, 1, 1, 0, 2'd0, 2'd0, 5'b00000, 3'b000};
    vecs[13] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 0, 0, 5'd0, 5'd0, 2'b00, 0, 1, 0, 1, 2'd0, 2'd0, 5'b11111, 3'b000};

    idle();
    nRST = 1'b0;
    #3;
    chk("reset_halt", 32'(halt), 32'd0);
    chk("reset_flush_req", 32'(flush_req), 32'd0);
    chk("reset_stall_cnt", 32'(stall_cnt), 32'd0);
    chk("reset_flush_cnt", 32'(flush_cnt), 32'd0);
    chk("reset_enables", 32'(ens()), 32'h1f);
    #4 nRST = 1'b1;
    tick();

    // Combinational vector table
    for (int i = 0; i < int'(NVEC); i++) begin
      rs_id = vecs[i].rs_id; rt_id = vecs[i].rt_id;
      rs_ex = vecs[i].rs_ex; rt_ex = vecs[i].rt_ex; wsel_ex = vecs[i].wsel_ex;
      RegWrite_ex = vecs[i].rw_ex; MemRead_ex = vecs[i].mr_ex;
      wsel_fwd[0] = vecs[i].w0; wsel_fwd[1] = vecs[i].w1; RegWrite_fwd = vecs[i].rwf;
      branch_taken = vecs[i].br; dmem_req = vecs[i].dreq;
      ihit = vecs[i].ih; dhit = vecs[i].dh;
      #1;
      chk($sformatf("vec%0d_forwardA", i), 32'(forwardA), 32'(vecs[i].fa));
      chk($sformatf("vec%0d_forwardB", i), 32'(forwardB), 32'(vecs[i].fb));
      chk($sformatf("vec%0d_enables", i), 32'(ens()), 32'(vecs[i].en));
      chk($sformatf("vec%0d_flushes", i), 32'(fls()), 32'(vecs[i].fl));
      tick();
    end

    // Load-use stall then normal advance
    idle();
    do_reset();
    set_lu();
    #1;
    chk("lu_enables", 32'(ens()), 32'h07);
    chk("lu_idex_flush", 32'(idex_flush), 32'd1);
    tick();
    idle();
    #1;
    chk("lu_release_enables", 32'(ens()), 32'h1f);
    chk("lu_stall_cnt", 32'(stall_cnt), 32'd1);
    tick();
    chk("lu_stall_cnt_hold", 32'(stall_cnt), 32'd1);

    // Branch overriding load-use: one stall plus one flush
    set_lu();
    branch_taken = 1'b1;
    #1;
    chk("br_lu_flushes", 32'(fls()), 32'h7);
    chk("br_lu_pc_en", 32'(pc_en), 32'd1);
    tick();
    idle();
    chk("br_lu_flush_cnt", 32'(flush_cnt), 32'd1);
    chk("br_lu_stall_cnt", 32'(stall_cnt), 32'd2);

    // Memory wait: three cycles without dhit
    do_reset();
    dmem_req = 1'b1;
    dhit = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("memwait_en_c%0d", c), 32'(ens()), 32'd0);
      tick();
    end
    dhit = 1'b1;
    #1;
    chk("memwait_release_en", 32'(ens()), 32'h1f);
    tick();
    chk("memwait_stall_cnt", 32'(stall_cnt), 32'd3);
    idle();

    // Halt without advance and stray flush_done in RUN must not move the FSM
    do_reset();
    halt_wb = 1'b1;
    ihit = 1'b0;
    tick();
    chk("halt_noadv_flush_req", 32'(flush_req), 32'd0);
    halt_wb = 1'b0;
    ihit = 1'b1;
    flush_done = 1'b1;
    tick();
    chk("run_flush_done_halt", 32'(halt), 32'd0);
    chk("run_flush_done_req", 32'(flush_req), 32'd0);
    flush_done = 1'b0;

    // Halt sequence with flush_done four cycles into DRAIN
    halt_wb = 1'b1;
    #1;
    chk("halt_entry_enables", 32'(ens()), 32'd0);
    tick();
    halt_wb = 1'b0;
    ihit = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("drain_flush_req_c%0d", c), 32'(flush_req), 32'd1);
      chk($sformatf("drain_enables_c%0d", c), 32'(ens()), 32'd0);
      tick();
    end
    chk("drain_stall_cnt_hold", 32'(stall_cnt), 32'd1);
    flush_done = 1'b1;
    tick();
    flush_done = 1'b0;
    ihit = 1'b1;
    chk("halted_halt", 32'(halt), 32'd1);
    chk("halted_flush_req", 32'(flush_req), 32'd0);
    chk("halted_enables", 32'(ens()), 32'd0);
    tick();
    chk("halted_sticky", 32'(halt), 32'd1);
    chk("halted_enables_2", 32'(ens()), 32'd0);
    #2 nRST = 1'b0;
    #1;
    chk("async_reset_halt", 32'(halt), 32'd0);
    chk("async_reset_enables", 32'(ens()), 32'h1f);
    #1 nRST = 1'b1;
    tick();

    // flush_done already present in the first DRAIN cycle
    halt_wb = 1'b1;
    tick();
    halt_wb = 1'b0;
    flush_done = 1'b1;
    chk("fast_drain_flush_req", 32'(flush_req), 32'd1);
    tick();
    flush_done = 1'b0;
    chk("fast_drain_halt", 32'(halt), 32'd1);
    #1 nRST = 1'b0;
    #1;
    chk("async_reset_flush_req", 32'(flush_req), 32'd0);
    #1 nRST = 1'b1;
    idle();

    // Saturation of the 4-bit stall counter
    tick();
    do_reset();
    ihit = 1'b0;
    for (int c = 0; c < 20; c++) tick();
    chk("stall_cnt_saturate", 32'(stall_cnt), 32'd15);
    idle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
